// File: rtl/instruction_packer.sv
// -----------------------------------------------------------------------------
// instruction_packer
//
// Purpose: packs consecutive decoded instructions into 60-bit dual-issue fetch
// words. Its layout is the exact inverse of the parser's. Slot 1 is packed
// MSB-aligned at bit 59. Slot 2 starts directly below slot 1. All unused low
// bits are zero. When a lone instruction is flushed, the bundle is completed
// with a NOP in slot 2.
//
// Slot encoding, MSB first: format, branch, opcode[6:0], reg[4:0], operand.
//   30b slot (format 1): 16-bit operand.
//   19b slot (format 0): 5-bit operand (operand_i[4:0]).
//
// Ports:
//   clock_i             clock, all state on posedge
//   reset_i             asynchronous active-high reset
//   enable_i            input instruction valid
//   ready_o             packer can accept this cycle
//   isBranch_i          branch bit
//   instructionFormat_i 0 = 19b slot, 1 = 30b slot
//   opcode_i            opcode
//   reg_i               first register operand
//   operand_i           immediate (30b) or operand in [4:0] (19b)
//   flush_i             close a half-filled bundle with a NOP partner
//   hold_i              downstream stall; a valid output is frozen
//   bundle_o            packed 60-bit word
//   enable_o            bundle_o valid
//   padCount_o          number of NOP-padded bundles emitted (wraps)
//
// Optional feature (macro PACKER_BRANCH_CLOSE_EN): a branch accepted into an
// empty packer is always issued alone, with a NOP partner.
// -----------------------------------------------------------------------------
module instruction_packer #(
  parameter logic [6:0] NOP_OPCODE = 7'h00,
  parameter int         PAD_CNT_W  = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  output logic                 ready_o,
  input  logic                 isBranch_i,
  input  logic                 instructionFormat_i,
  input  logic [6:0]           opcode_i,
  input  logic [4:0]           reg_i,
  input  logic [15:0]          operand_i,
  input  logic                 flush_i,
  input  logic                 hold_i,
  output logic [59:0]          bundle_o,
  output logic                 enable_o,
  output logic [PAD_CNT_W-1:0] padCount_o
);

`ifdef PACKER_BRANCH_CLOSE_EN
  localparam logic BRANCH_CLOSE = 1'b1;
`else
  localparam logic BRANCH_CLOSE = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_CLOSE = 2'd2
  } state_t;

  // Slots are kept MSB-aligned in a 30-bit field. A 19b slot has 11 zero LSBs.
  // Bit 29 is the format bit, so the slot length is recoverable from it.
  function automatic logic [59:0] f_combine(input logic [29:0] slot1,
                                            input logic [29:0] slot2);
    logic [59:0] hi;
    logic [59:0] lo;
    hi = {slot1, 30'd0};
    if (slot1[29]) begin
      lo = {30'd0, slot2};
    end else begin
      lo = {19'd0, slot2, 11'd0};
    end
    return hi | lo;
  endfunction

  state_t                r_state;
  state_t                w_state_next;
  logic [29:0]           r_slot1;
  logic [29:0]           w_slot1_next;
  logic [59:0]           r_bundle;
  logic                  r_valid;
  logic [PAD_CNT_W-1:0]  r_pad_cnt;

  logic [29:0]           w_in_slot;
  logic [29:0]           w_nop_slot;
  logic [29:0]           w_partner;
  logic                  w_out_free;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_load_pad;

  assign w_in_slot  = instructionFormat_i
                    ? {1'b1, isBranch_i, opcode_i, reg_i, operand_i}
                    : {1'b0, isBranch_i, opcode_i, reg_i, operand_i[4:0], 11'd0};
  assign w_nop_slot = {1'b0, 1'b0, NOP_OPCODE, 5'd0, 5'd0, 11'd0};
  assign w_out_free = !r_valid || !hold_i;
  assign w_accept   = enable_i && ready_o;
  assign w_partner  = w_load_pad ? w_nop_slot : w_in_slot;

  // Ready: combinational from state and the output register.
  always_comb begin
    ready_o = 1'b0;
    if (reset_i) begin
      ready_o = 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: ready_o = 1'b1;
        ST_HALF:  ready_o = w_out_free;
        ST_CLOSE: ready_o = 1'b0;
        default:  ready_o = 1'b0;
      endcase
    end
  end

  // Next state, slot 1 capture, and output-load decisions.
  always_comb begin
    w_state_next = r_state;
    w_slot1_next = r_slot1;
    w_load       = 1'b0;
    w_load_pad   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_slot1_next = w_in_slot;
          w_state_next = (BRANCH_CLOSE && isBranch_i) ? ST_CLOSE : ST_HALF;
        end else begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_HALF: begin
        // A pairing wins over a simultaneous flush.
        if (w_accept) begin
          w_load       = 1'b1;
          w_state_next = ST_EMPTY;
        end else if (flush_i) begin
          if (w_out_free) begin
            w_load       = 1'b1;
            w_load_pad   = 1'b1;
            w_state_next = ST_EMPTY;
          end else begin
            w_state_next = ST_CLOSE;
          end
        end else begin
          w_state_next = ST_HALF;
        end
      end
      ST_CLOSE: begin
        if (w_out_free) begin
          w_load       = 1'b1;
          w_load_pad   = 1'b1;
          w_state_next = ST_EMPTY;
        end else begin
          w_state_next = ST_CLOSE;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
  end

  // State, slot 1 and output register. The output only changes when free.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= ST_EMPTY;
      r_slot1   <= 30'd0;
      r_bundle  <= 60'd0;
      r_valid   <= 1'b0;
      r_pad_cnt <= {PAD_CNT_W{1'b0}};
    end else begin
      r_state <= w_state_next;
      r_slot1 <= w_slot1_next;
      if (w_out_free) begin
        if (w_load) begin
          r_bundle <= f_combine(r_slot1, w_partner);
          r_valid  <= 1'b1;
        end else begin
          r_valid  <= 1'b0;
        end
      end
      if (w_load_pad) begin
        r_pad_cnt <= r_pad_cnt + {{(PAD_CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bundle_o   = r_bundle;
  assign enable_o   = r_valid;
  assign padCount_o = r_pad_cnt;

endmodule

// File: tb/tb_instruction_packer.sv
// -----------------------------------------------------------------------------
// tb_instruction_packer
//
// Directed bench for instruction_packer. A field-level reference model
// predicts ready_o, enable_o, bundle_o and padCount_o on every cycle. Literal
// bundle values pin the model at key points.
// -----------------------------------------------------------------------------
module tb_instruction_packer;

  typedef struct packed {
    logic        fmt;
    logic        br;
    logic [6:0]  op;
    logic [4:0]  rg;
    logic [15:0] opnd;
  } instr_t;

`ifdef PACKER_BRANCH_CLOSE_EN
  localparam bit BR_CLOSE = 1'b1;
`else
  localparam bit BR_CLOSE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_i = 1'b0;
  logic        ready_o;
  logic        isBranch_i = 1'b0;
  logic        instructionFormat_i = 1'b0;
  logic [6:0]  opcode_i = 7'h00;
  logic [4:0]  reg_i = 5'h00;
  logic [15:0] operand_i = 16'h0000;
  logic        flush_i = 1'b0;
  logic        hold_i = 1'b0;
  logic [59:0] bundle_o;
  logic        enable_o;
  logic [15:0] padCount_o;

  int n_assert = 0;
  int n_fail   = 0;

  instruction_packer #(.NOP_OPCODE(7'h00), .PAD_CNT_W(16)) dut (
    .clock_i             (clk),
    .reset_i             (rst),
    .enable_i            (enable_i),
    .ready_o             (ready_o),
    .isBranch_i          (isBranch_i),
    .instructionFormat_i (instructionFormat_i),
    .opcode_i            (opcode_i),
    .reg_i               (reg_i),
    .operand_i           (operand_i),
    .flush_i             (flush_i),
    .hold_i              (hold_i),
    .bundle_o            (bundle_o),
    .enable_o            (enable_o),
    .padCount_o          (padCount_o)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Writes the n low bits of v into w, MSB first, starting at bit p.
  function automatic logic [59:0] put(input logic [59:0] w, input int p,
                                      input logic [15:0] v, input int n);
    logic [59:0] r;
    r = w;
    for (int i = 0; i < n; i++) r[p - i] = v[n - 1 - i];
    return r;
  endfunction

  // Builds a bundle by laying the fields of a then b end to end from bit 59.
  function automatic logic [59:0] pack(input instr_t a, input instr_t b);
    logic [59:0] w;
    int          p;
    instr_t      x;
    w = '0;
    p = 59;
    for (int k = 0; k < 2; k++) begin
      x = (k == 0) ? a : b;
      w = put(w, p, {15'd0, x.fmt}, 1);  p = p - 1;
      w = put(w, p, {15'd0, x.br}, 1);   p = p - 1;
      w = put(w, p, {9'd0, x.op}, 7);    p = p - 7;
      w = put(w, p, {11'd0, x.rg}, 5);   p = p - 5;
      if (x.fmt) begin
        w = put(w, p, x.opnd, 16);       p = p - 16;
      end else begin
        w = put(w, p, x.opnd, 5);        p = p - 5;
      end
    end
    return w;
  endfunction

  localparam instr_t NOP = '{fmt:1'b0, br:1'b0, op:7'h00, rg:5'h00, opnd:16'h0000};

  // Reference model state.
  bit          m_held   = 1'b0;
  bit          m_close  = 1'b0;
  bit          m_valid  = 1'b0;
  instr_t      m_slot   = '0;
  logic [59:0] m_bundle = '0;
  logic [15:0] m_pad    = '0;

  function automatic bit m_ready();
    if (rst) return 1'b0;
    if (!m_held) return 1'b1;
    if (m_close) return 1'b0;
    return (!m_valid || !hold_i);
  endfunction

  // Reference model: advanced at each clock edge, or cleared at reset.
  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_held = 1'b0; m_close = 1'b0; m_valid = 1'b0;
        m_bundle = '0; m_pad = '0;
      end else begin : step
        bit          free;
        bit          acc;
        bit          emit;
        logic [59:0] nb;
        instr_t      in;
        in   = {instructionFormat_i, isBranch_i, opcode_i, reg_i, operand_i};
        free = !m_valid || !hold_i;
        acc  = enable_i && m_ready();
        emit = 1'b0;
        nb   = '0;
        if (!m_held) begin
          if (acc) begin
            m_slot  = in;
            m_held  = 1'b1;
            m_close = BR_CLOSE && in.br;
          end
        end else if (m_close) begin
          if (free) begin
            emit = 1'b1; nb = pack(m_slot, NOP); m_pad = m_pad + 16'd1;
            m_held = 1'b0; m_close = 1'b0;
          end
        end else if (acc) begin
          emit = 1'b1; nb = pack(m_slot, in); m_held = 1'b0;
        end else if (flush_i) begin
          if (free) begin
            emit = 1'b1; nb = pack(m_slot, NOP); m_pad = m_pad + 16'd1;
            m_held = 1'b0;
          end else begin
            m_close = 1'b1;
          end
        end
        if (free) begin
          m_valid = emit;
          if (emit) m_bundle = nb;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("ready_o",    ready_o,    m_ready());
      chk("enable_o",   enable_o,   m_valid);
      chk("padCount_o", padCount_o, m_pad);
      chk("bundle_o",   bundle_o,   m_bundle);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one instruction and waits (bounded) until it is accepted.
  task automatic send(input instr_t x);
    bit got;
    int n;
    instructionFormat_i = x.fmt;
    isBranch_i          = x.br;
    opcode_i            = x.op;
    reg_i               = x.rg;
    operand_i           = x.opnd;
    enable_i            = 1'b1;
    got = 1'b0;
    n   = 0;
    do begin
      @(negedge clk);
      got = ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 20);
    chk("accept_within_bound", got, 1'b1);
    enable_i = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
  endtask

  instr_t A, B, A2, B2, F1, X, Y;

  initial begin : stim
    A  = '{fmt:1'b1, br:1'b0, op:7'h12, rg:5'h03, opnd:16'hABCD};
    B  = '{fmt:1'b0, br:1'b1, op:7'h05, rg:5'h1F, opnd:16'h000A};
    A2 = '{fmt:1'b0, br:1'b0, op:7'h01, rg:5'h00, opnd:16'h0011};
    B2 = '{fmt:1'b1, br:1'b0, op:7'h02, rg:5'h00, opnd:16'h1234};
    F1 = '{fmt:1'b1, br:1'b0, op:7'h7F, rg:5'h15, opnd:16'h5A5A};
    X  = '{fmt:1'b0, br:1'b1, op:7'h33, rg:5'h02, opnd:16'h0004};
    Y  = '{fmt:1'b0, br:1'b0, op:7'h44, rg:5'h01, opnd:16'h001F};

    // Reset state.
    #1 rst = 1'b1;
    tick(2);
    chk("reset_ready",  ready_o,    1'b0);
    chk("reset_enable", enable_o,   1'b0);
    chk("reset_bundle", bundle_o,   60'h0);
    chk("reset_pad",    padCount_o, 16'h0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", ready_o, 1'b1);

    // Pair 30b + 19b.
    send(A);
    send(B);
    chk("pair_30_19_bundle", bundle_o, 60'h890EAF350BF5000);
    chk("pair_30_19_enable", enable_o, 1'b1);
    tick(1);
    chk("idle_enable_clears", enable_o, 1'b0);
    chk("idle_bundle_kept",   bundle_o, 60'h890EAF350BF5000);

    // Pair 19b + 30b.
    send(A2);
    send(B2);
    chk("pair_19_30_bundle", bundle_o, 60'h00823020091A000);

    // Flush a lone instruction, then a flush in EMPTY does nothing.
    send(F1);
    pulse_flush();
    chk("flush_bundle", bundle_o,   60'hBFD569680000000);
    chk("flush_enable", enable_o,   1'b1);
    chk("flush_pad",    padCount_o, 16'd1);
    tick(1);
    pulse_flush();
    chk("empty_flush_pad",    padCount_o, 16'd1);
    chk("empty_flush_enable", enable_o,   1'b0);

    // Backpressure: held bundle plus held slot 1, then release and pair.
    send(A);
    send(B);
    hold_i = 1'b1;
    send(A2);
    repeat (5) begin
      @(negedge clk);
      chk("hold_ready",  ready_o,  1'b0);
      chk("hold_bundle", bundle_o, 60'h890EAF350BF5000);
      chk("hold_enable", enable_o, 1'b1);
    end
    @(posedge clk);
    #1;
    hold_i = 1'b0;
    send(B2);
    chk("release_pair_bundle", bundle_o, 60'h00823020091A000);
    chk("release_pair_enable", enable_o, 1'b1);

    // Flush during hold goes through CLOSE and emits after release.
    hold_i = 1'b1;
    send(A);
    pulse_flush();
    tick(2);
    chk("close_hold_bundle", bundle_o,   60'h00823020091A000);
    chk("close_hold_pad",    padCount_o, 16'd1);
    chk("close_hold_ready",  ready_o,    1'b0);
    hold_i = 1'b0;
    tick(1);
    chk("close_emit_bundle", bundle_o,   60'h890EAF340000000);
    chk("close_emit_enable", enable_o,   1'b1);
    chk("close_emit_pad",    padCount_o, 16'd2);

    // Asynchronous reset in HALF with a valid output.
    send(A);
    send(B);
    hold_i = 1'b1;
    send(A2);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_enable", enable_o,   1'b0);
    chk("async_reset_bundle", bundle_o,   60'h0);
    chk("async_reset_ready",  ready_o,    1'b0);
    chk("async_reset_pad",    padCount_o, 16'h0);
    hold_i = 1'b0;
    tick(1);
    rst = 1'b0;
    send(A2);
    send(B2);
    chk("post_reset_pair", bundle_o, 60'h00823020091A000);

    // Branch followed by a non-branch.
    send(X);
    send(Y);
`ifdef PACKER_BRANCH_CLOSE_EN
    chk("branch_pad",    padCount_o, 16'd1);
    chk("branch_bundle", bundle_o,   60'h598880000000000);
    chk("branch_enable", enable_o,   1'b0);
`else
    chk("branch_pad",    padCount_o, 16'd0);
    chk("branch_bundle", bundle_o,   60'h59888440FC00000);
    chk("branch_enable", enable_o,   1'b1);
`endif
    pulse_flush();
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
